io_bus_responder: RTL and testbench

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_responder_pkg.sv | 36 +++
 rtl/io_tx_fifo.sv | 51 +++++
 rtl/io_bus_responder.sv | 129 ++++++++++++
 tb/tb_io_bus_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared encodings for the IO bus responder: request codes, register map,
// STATUS bit layout and the default decode base.
package io_responder_pkg;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'b00,
    CTL_WRITE = 2'b01,
    CTL_READ  = 2'b10,
    CTL_RSVD  = 2'b11
  } ctl_e;

  localparam logic [3:0] IDX_STATUS     = 4'd0;
  localparam logic [3:0] IDX_TX_DATA    = 4'd1;
  localparam logic [3:0] IDX_RX_DATA    = 4'd2;
  localparam logic [3:0] IDX_CNT_LO     = 4'd3;
  localparam logic [3:0] IDX_CNT_HI     = 4'd4;
  localparam logic [3:0] IDX_STATUS_CLR = 4'd5;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_CNT_LSB  = 4;
  localparam int ST_TX_DROP  = 8;

  localparam logic [7:0] IO_BASE_DEFAULT = 8'hFF;

  // Decoded request; rd/wr are only set when the base address matches.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  idx;
    logic [15:0] wdata;
  } io_req_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the TX sink. Push is ignored when full at the start of
// the cycle, even if a pop frees a slot on the same edge.
module io_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder: TX FIFO, single-byte RX holding register,
// free-running counter with shadowed high half, and scratch registers.
module io_bus_responder
  import io_responder_pkg::*;
#(
  parameter int         TX_DEPTH = 8,
  parameter logic [7:0] IO_BASE  = IO_BASE_DEFAULT
) (
  input  logic        main_clk,
  input  logic        main_reset,
  input  logic [1:0]  control_io,
  input  logic [31:0] address_io,
  input  logic [15:0] data_in_io,
  output logic [15:0] data_out_io,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  io_req_t          req;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic [CW-1:0]    tx_count;
  logic [6:0]       tx_count_ext;
  logic [15:0]      status, rd_mux;
  logic             rx_rd, sts_clr, ovr_set, drop_set;

  logic [7:0]       rx_byte;
  logic             rx_valid, rx_overrun, tx_drop;
  logic [31:0]      counter;
  logic [15:0]      shadow;
  logic [7:0][15:0] scratch;
  logic             rd_vld_q;
  logic [15:0]      rd_data_q;

  logic unused_addr;
  assign unused_addr = ^{address_io[23:5], address_io[0]};

  always_comb begin
    req       = '0;
    req.idx   = address_io[4:1];
    req.wdata = data_in_io;
    if (address_io[31:24] == IO_BASE) begin
      req.rd = (control_io == CTL_READ);
      req.wr = (control_io == CTL_WRITE);
    end
  end

  assign tx_push  = req.wr && (req.idx == IDX_TX_DATA);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign rx_rd    = req.rd && (req.idx == IDX_RX_DATA);
  assign sts_clr  = req.wr && (req.idx == IDX_STATUS_CLR);
  assign ovr_set  = rx_strobe && rx_valid && !rx_rd;
  assign drop_set = tx_push && tx_full;

  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (main_clk),
    .rst   (main_reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (req.wdata[7:0]),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign tx_count_ext = 7'(tx_count);

  always_comb begin
    status                       = '0;
    status[ST_TX_FULL]           = tx_full;
    status[ST_TX_EMPTY]          = tx_empty;
    status[ST_RX_VALID]          = rx_valid;
    status[ST_RX_OVR]            = rx_overrun;
    status[ST_CNT_LSB +: 4]      = (tx_count_ext > 7'd15) ? 4'hF : tx_count_ext[3:0];
    status[ST_TX_DROP]           = tx_drop;
  end

  // Read data reflects state at the start of the request cycle.
  always_comb begin
    rd_mux = '0;
    case (req.idx)
      IDX_STATUS:  rd_mux = status;
      IDX_RX_DATA: rd_mux = {8'h00, rx_byte};
      IDX_CNT_LO:  rd_mux = counter[15:0];
      IDX_CNT_HI:  rd_mux = shadow;
      default:     if (req.idx[3]) rd_mux = scratch[req.idx[2:0]];
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      data_out_io <= '0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_drop     <= 1'b0;
      counter     <= '0;
      shadow      <= '0;
      scratch     <= '0;
    end else begin
      counter   <= counter + 32'd1;
      // Two-stage read pipe: capture, then present.
      rd_vld_q  <= req.rd;
      rd_data_q <= rd_mux;
      if (rd_vld_q) data_out_io <= rd_data_q;

      if (rx_strobe) rx_byte <= rx_data;
      rx_valid <= rx_strobe || (rx_valid && !rx_rd);

      // Set beats clear on the sticky bits.
      if (ovr_set)                       rx_overrun <= 1'b1;
      else if (sts_clr && data_in_io[3]) rx_overrun <= 1'b0;
      if (drop_set)                      tx_drop <= 1'b1;
      else if (sts_clr && data_in_io[8]) tx_drop <= 1'b0;

      if (req.rd && (req.idx == IDX_CNT_LO)) shadow <= counter[31:16];
      if (req.wr && req.idx[3])              scratch[req.idx[2:0]] <= req.wdata;
    end
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed and randomized checks of io_bus_responder against a queue/array
// reference model of the register map.
module tb_io_bus_responder;
  import io_responder_pkg::*;

  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'hFF;

  logic        main_clk = 1'b0;
  logic        main_reset = 1'b1;
  logic [1:0]  control_io = 2'b00;
  logic [31:0] address_io = '0;
  logic [15:0] data_in_io = '0;
  logic [15:0] data_out_io;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_strobe = 1'b0;

  always #5 main_clk = ~main_clk;

  io_bus_responder #(.TX_DEPTH(DEPTH), .IO_BASE(BASE)) dut (
    .main_clk    (main_clk),
    .main_reset  (main_reset),
    .control_io  (control_io),
    .address_io  (address_io),
    .data_in_io  (data_in_io),
    .data_out_io (data_out_io),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_rxv, m_ov, m_drop, m_pv;
  logic [7:0]  m_rxb;
  logic [31:0] m_cnt;
  logic [15:0] m_sh, m_dout, m_pd;
  logic [15:0] m_scr[8];
  logic        ready_lvl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    int n;
    logic [15:0] s;
    n = m_q.size();
    s = '0;
    s[0]   = (n == DEPTH);
    s[1]   = (n == 0);
    s[2]   = m_rxv;
    s[3]   = m_ov;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    s[8]   = m_drop;
    return s;
  endfunction

  // One bus cycle: drive, advance the model, clock, then check at negedge.
  task automatic step(input logic [1:0] c, input logic [7:0] base, input logic [3:0] idx,
                      input logic [15:0] d, input logic strb, input logic [7:0] rxd,
                      input logic trdy, input logic rst);
    logic [31:0] junk;
    logic        rd, wr, full, rx_rd;
    logic [15:0] rv;
    junk       = $urandom();
    control_io = c;
    address_io = {base, junk[18:0], idx, junk[31]};
    data_in_io = d;
    rx_strobe  = strb;
    rx_data    = rxd;
    tx_ready   = trdy;
    main_reset = rst;
    if (rst) begin
      m_q.delete();
      m_rxv = 0; m_ov = 0; m_drop = 0; m_pv = 0;
      m_rxb = '0; m_cnt = '0; m_sh = '0; m_dout = '0; m_pd = '0;
      for (int i = 0; i < 8; i++) m_scr[i] = '0;
    end else begin
      rd    = (base == BASE) && (c == 2'b10);
      wr    = (base == BASE) && (c == 2'b01);
      full  = (m_q.size() == DEPTH);
      rx_rd = rd && (idx == 4'd2);
      rv    = '0;
      if (rd) begin
        if      (idx == 4'd0) rv = m_status();
        else if (idx == 4'd2) rv = {8'h00, m_rxb};
        else if (idx == 4'd3) rv = m_cnt[15:0];
        else if (idx == 4'd4) rv = m_sh;
        else if (idx[3])      rv = m_scr[idx[2:0]];
      end
      if (m_pv) m_dout = m_pd;
      m_pv = rd;
      m_pd = rv;
      if (m_q.size() != 0 && trdy) void'(m_q.pop_front());
      if (wr && idx == 4'd5 && d[3]) m_ov = 0;
      if (wr && idx == 4'd5 && d[8]) m_drop = 0;
      if (wr && idx == 4'd1) begin
        if (full) m_drop = 1;
        else      m_q.push_back(d[7:0]);
      end
      if (strb) begin
        if (m_rxv && !rx_rd) m_ov = 1;
        m_rxb = rxd;
        m_rxv = 1;
      end else if (rx_rd) begin
        m_rxv = 0;
      end
      if (rd && idx == 4'd3) m_sh = m_cnt[31:16];
      if (wr && idx[3]) m_scr[idx[2:0]] = d;
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge main_clk);
    @(negedge main_clk);
    chk("dout", 32'(data_out_io), 32'(m_dout));
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
  endtask

  task automatic idle();                         step(2'b00, BASE, 4'd0, 16'h0, 1'b0, 8'h0, ready_lvl, 1'b0); endtask
  task automatic rd_reg(input logic [3:0] i);    step(2'b10, BASE, i, 16'h0, 1'b0, 8'h0, ready_lvl, 1'b0); endtask
  task automatic wr_reg(input logic [3:0] i, input logic [15:0] d);
    step(2'b01, BASE, i, d, 1'b0, 8'h0, ready_lvl, 1'b0);
  endtask
  task automatic rx(input logic [7:0] b);        step(2'b00, BASE, 4'd0, 16'h0, 1'b1, b, ready_lvl, 1'b0); endtask
  task automatic do_reset();                     repeat (2) step(2'b10, BASE, 4'd8, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1); endtask

  initial begin
    @(negedge main_clk);
    do_reset();
    chk("rst_dout", 32'(data_out_io), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);

    // Counter reads 0 in the first cycle after reset
    rd_reg(IDX_CNT_LO); idle();
    chk("cnt_first", 32'(data_out_io), 32'h0);

    // Scratch reset value and write/read
    rd_reg(4'd8); idle();
    chk("scr8_rst", 32'(data_out_io), 32'h0);
    wr_reg(4'd8, 16'hBEEF); rd_reg(4'd8); idle();
    chk("scr8_rw", 32'(data_out_io), 32'hBEEF);

    // FIFO overflow and drain
    ready_lvl = 1'b0;
    for (int i = 1; i <= 9; i++) wr_reg(IDX_TX_DATA, 16'(i));
    rd_reg(IDX_STATUS); idle();
    chk("status_full", 32'(data_out_io), 32'h0181);
    ready_lvl = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("tx_order", 32'(tx_data), 32'(i));
      idle();
    end
    chk("tx_drained", 32'(tx_valid), 32'h0);
    ready_lvl = 1'b0;

    // RX overrun and clear
    do_reset();
    rx(8'h41); rx(8'h42);
    rd_reg(IDX_STATUS); idle();
    chk("rx_ovr_bits", 32'(data_out_io[3:2]), 32'h3);
    rd_reg(IDX_RX_DATA); idle();
    chk("rx_last", 32'(data_out_io), 32'h0042);
    wr_reg(IDX_STATUS_CLR, 16'h0008); rd_reg(IDX_STATUS); idle();
    chk("rx_clr_bits", 32'(data_out_io[3:2]), 32'h0);

    // Strobe coincident with RX read
    rx(8'h33);
    step(2'b10, BASE, IDX_RX_DATA, 16'h0, 1'b1, 8'h55, 1'b0, 1'b0);
    idle();
    chk("rx_coinc_old", 32'(data_out_io), 32'h0033);
    rd_reg(IDX_STATUS); idle();
    chk("rx_coinc_bits", 32'(data_out_io[3:2]), 32'h1);
    rd_reg(IDX_RX_DATA); idle();
    chk("rx_coinc_new", 32'(data_out_io), 32'h0055);

    // Counter shadow across a 16-bit carry
    dut.counter = 32'h0001_FFFF;
    m_cnt       = 32'h0001_FFFF;
    rd_reg(IDX_CNT_LO); rd_reg(IDX_CNT_HI);
    chk("cnt_lo", 32'(data_out_io), 32'hFFFF);
    idle();
    chk("cnt_hi", 32'(data_out_io), 32'h0001);

    // Non-decoded requests have no effect
    wr_reg(4'd9, 16'h1234); rd_reg(4'd9); idle();
    chk("scr9", 32'(data_out_io), 32'h1234);
    step(2'b01, 8'hFE, 4'd9, 16'hAAAA, 1'b0, 8'h0, 1'b0, 1'b0);
    step(2'b11, BASE, 4'd9, 16'h5555, 1'b0, 8'h0, 1'b0, 1'b0);
    step(2'b10, 8'hFE, 4'd0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    step(2'b11, BASE, 4'd0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    idle();
    chk("nodec_hold", 32'(data_out_io), 32'h1234);
    rd_reg(4'd9); idle();
    chk("nodec_scr9", 32'(data_out_io), 32'h1234);

    // Reset discards an in-flight read
    rd_reg(4'd9);
    step(2'b00, BASE, 4'd0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    chk("rst_inflight", 32'(data_out_io), 32'h0);
    idle();
    chk("rst_discard", 32'(data_out_io), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  c;
      logic [7:0]  b;
      logic [3:0]  ix;
      logic [15:0] d;
      c  = 2'($urandom_range(0, 3));
      b  = ($urandom_range(0, 7) == 0) ? 8'hFE : BASE;
      ix = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      d  = 16'($urandom());
      step(c, b, ix, d, 1'($urandom_range(0, 3) == 0), 8'($urandom()),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 249) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
